// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free physical indices with a
// speculative allocation head, a committed head for flush recovery, and a return tail.
module phys_free_list #(
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned PHYS_W   = $clog2(NUM_PHYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PHYS_W-1:0] alloc_phys,
    input  logic              commit_valid,
    input  logic [PHYS_W-1:0] commit_phys_old,
    input  logic              flush,
    output logic              empty,
    output logic [PHYS_W:0]   free_count,
    output logic              err_overflow
);

    localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

    logic [PHYS_W-1:0] fl [DEPTH];
    logic [PTR_W-1:0]  spec_head;
    logic [PTR_W-1:0]  arch_head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  free_diff;
    logic              commit_zero;
    logic              commit_full;
    logic              commit_write;

    // Allocation side is purely combinational off the speculative head.
    assign free_diff  = tail - spec_head;
    assign free_count = (PHYS_W + 1)'(free_diff);
    assign empty      = (free_diff == '0);
    assign alloc_phys = fl[spec_head[IDX_W-1:0]];
    assign alloc_gnt  = alloc_req && !empty && !flush;

    // In legal operation tail-arch_head stays at DEPTH because a commit frees the
    // slot at arch_head as it writes at tail (same index); a true overflow is a
    // return while every entry is already free and unallocated.
    assign commit_zero  = commit_valid && (commit_phys_old == '0);
    assign commit_full  = commit_valid && (free_diff == PTR_DEPTH);
    assign commit_write = commit_valid && !commit_zero && !commit_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_head    <= '0;
            arch_head    <= '0;
            tail         <= PTR_DEPTH;
            err_overflow <= 1'b0;
        end else begin
            if (commit_valid) begin
                arch_head <= arch_head + PTR_ONE;
            end
            if (commit_write) begin
                tail <= tail + PTR_ONE;
            end
            if (commit_zero || commit_full) begin
                err_overflow <= 1'b1;
            end
            if (flush) begin
                spec_head <= arch_head + PTR_W'(commit_valid);
            end else if (alloc_gnt) begin
                spec_head <= spec_head + PTR_ONE;
            end
        end
    end

    // Free-list storage; reset contents are the registers not mapped at reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fl[i] <= PHYS_W'(int'(NUM_ARCH) + i);
            end
        end else if (commit_write) begin
            fl[tail[IDX_W-1:0]] <= commit_phys_old;
        end
    end

    // A commit must retire an instruction that actually holds an allocation.
    always @(posedge clk) begin
        if (!rst && commit_valid) begin
            assert (arch_head != spec_head);
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed table-driven bench for phys_free_list: drain/wrap table plus
// hand-built flush, commit+flush, sticky-error and async-reset sequences.
module tb_phys_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [5:0] alloc_phys;
    logic       commit_valid;
    logic [5:0] commit_phys_old;
    logic       flush;
    logic       empty;
    logic [6:0] free_count;
    logic       err_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic req;
        logic cv;
        int   old;
        logic fl;
        logic e_gnt;
        int   e_phys;
        int   e_free;
        logic e_empty;
        logic e_err;
    } vec_t;

    vec_t tbl[$];

    phys_free_list dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_phys      (alloc_phys),
        .commit_valid    (commit_valid),
        .commit_phys_old (commit_phys_old),
        .flush           (flush),
        .empty           (empty),
        .free_count      (free_count),
        .err_overflow    (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic req, logic cv, int old, logic fl, logic g,
                                int p, int f, logic em, logic er);
        vec_t v;
        v.req = req; v.cv = cv; v.old = old; v.fl = fl;
        v.e_gnt = g; v.e_phys = p; v.e_free = f; v.e_empty = em; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input vec_t v);
        chk({tag, ".gnt"},   idx, int'(alloc_gnt),    int'(v.e_gnt));
        chk({tag, ".free"},  idx, int'(free_count),   v.e_free);
        chk({tag, ".empty"}, idx, int'(empty),        int'(v.e_empty));
        chk({tag, ".err"},   idx, int'(err_overflow), int'(v.e_err));
        if (!v.e_empty) chk({tag, ".phys"}, idx, int'(alloc_phys), v.e_phys);
    endtask

    // Drive one cycle, check combinational outputs mid-cycle, then cross the edge.
    task automatic step(input string tag, input int idx, input vec_t v);
        alloc_req       = v.req;
        commit_valid    = v.cv;
        commit_phys_old = 6'(v.old);
        flush           = v.fl;
        #2;
        check_outputs(tag, idx, v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_req = 1'b0; commit_valid = 1'b0; commit_phys_old = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Drain, no-bypass on empty, returns with index wrap, alloc+commit balance.
        tbl.push_back(mk(0, 0, 0, 0, 0, 32, 32, 0, 0));
        for (int i = 0; i < 32; i++) tbl.push_back(mk(1, 0, 0, 0, 1, 32 + i, 32 - i, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 5, 2, 0, 0));
        tbl.push_back(mk(1, 1, 8, 0, 1, 5, 3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 6, 3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 7, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 8, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) step("drain", i, tbl[i]);

        // Flush with no commits restores the reset head; request ignored in flush cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step("flsh_alloc", i, mk(1, 0, 0, 0, 1, 32 + i, 32 - i, 0, 0));
        step("flsh", 0, mk(1, 0, 0, 1, 0, 36, 28, 0, 0));
        step("flsh_after", 0, mk(0, 0, 0, 0, 0, 32, 32, 0, 0));

        // Commit in the flush cycle: head lands one past the committed allocation.
        do_reset();
        for (int i = 0; i < 4; i++) step("cflsh_alloc", i, mk(1, 0, 0, 0, 1, 32 + i, 32 - i, 0, 0));
        step("cflsh", 0, mk(0, 1, 3, 1, 0, 36, 28, 0, 0));
        step("cflsh_after", 0, mk(0, 0, 0, 0, 0, 33, 32, 0, 0));
        for (int i = 0; i < 31; i++) step("cflsh_walk", i, mk(1, 0, 0, 0, 1, 33 + i, 32 - i, 0, 0));
        step("cflsh_tail", 0, mk(0, 0, 0, 0, 0, 3, 1, 0, 0));

        // Returning p0 sets a sticky error and writes nothing.
        do_reset();
        step("err_alloc", 0, mk(1, 0, 0, 0, 1, 32, 32, 0, 0));
        step("err_commit", 0, mk(0, 1, 0, 0, 0, 33, 31, 0, 0));
        step("err_set", 0, mk(0, 0, 0, 0, 0, 33, 31, 0, 1));
        for (int i = 0; i < 26; i++) step("err_hold", i, mk(1, 0, 0, 0, 1, 33 + i, 31 - i, 0, 1));
        step("err_five", 0, mk(0, 0, 0, 0, 0, 59, 5, 0, 1));

        // Asynchronous reset mid-cycle, checked before any clock edge.
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 0, mk(0, 0, 0, 0, 0, 32, 32, 0, 0));
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
